// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the debug-visible state encoding and the counter width function.
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABILIZE = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT_HOLD = 3'd4
    } seq_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock into the clock domain.
// The chain clears on reset so a fresh lock is always seen as a rising event.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Waits for a stable PLL lock, then releases staged resets one at a time;
// re-asserts them all on lock loss or on a soft request, and counts lock losses.
//
// state        | meaning
// WAIT_LOCK    | all resets held, waiting for synchronized lock
// STABILIZE    | all resets held, counting consecutive locked cycles
// RELEASE      | dropping reset bits in index order, one per gap
// RUN          | every reset released
// SOFT_HOLD    | all resets held for one gap after a soft request
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int NUM_RESETS         = 3,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  soft_reset_req,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  all_released,
    output logic [2:0]            seq_state,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int CNT_MAX = ((LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                              LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES) - 1;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int IDX_W   = cnt_width(NUM_RESETS - 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_RESETS - 1);

    logic locked_s;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (pll_locked),
        .q      (locked_s)
    );

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_RESETS-1:0] rst_q, rst_d;
    logic                  all_rel_q, all_rel_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    logic                  lock_lost;
    logic                  enter_rel;
    logic [IDX_W-1:0]      idx_nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_d     = rst_q;
        all_rel_d = all_rel_q;
        loss_d    = loss_q;
        lock_lost = 1'b0;
        enter_rel = 1'b0;
        idx_nxt   = idx_q + 1'b1;

        case (state_q)
            ST_WAIT_LOCK: begin
                rst_d     = '1;
                all_rel_d = 1'b0;
                if (locked_s) begin
                    cnt_d   = '0;
                    state_d = ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    enter_rel = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!locked_s) begin
                    lock_lost = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d          = '0;
                    idx_d          = idx_nxt;
                    rst_d[idx_nxt] = 1'b0;
                    if (idx_nxt == IDX_LAST) begin
                        state_d   = ST_RUN;
                        all_rel_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    lock_lost = 1'b1;
                end else if (soft_reset_req) begin
                    state_d   = ST_SOFT_HOLD;
                    rst_d     = '1;
                    all_rel_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            ST_SOFT_HOLD: begin
                if (!locked_s) begin
                    lock_lost = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    enter_rel = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        // Bit 0 drops on the very edge that enters RELEASE; a single reset skips straight to RUN.
        if (enter_rel) begin
            cnt_d    = '0;
            idx_d    = '0;
            rst_d    = '1;
            rst_d[0] = 1'b0;
            if (NUM_RESETS == 1) begin
                state_d   = ST_RUN;
                all_rel_d = 1'b1;
            end else begin
                state_d = ST_RELEASE;
            end
        end

        if (lock_lost) begin
            state_d   = ST_WAIT_LOCK;
            rst_d     = '1;
            all_rel_d = 1'b0;
            cnt_d     = '0;
            if (loss_q != '1) begin
                loss_d = loss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_q     <= '1;
            all_rel_q <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_q     <= rst_d;
            all_rel_q <= all_rel_d;
            loss_q    <= loss_d;
        end
    end

    assign rst_out         = rst_q;
    assign all_released    = all_rel_q;
    assign seq_state       = state_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a timeline model checked every cycle, plus
// directed scenarios with hand-computed edge expectations.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int L    = 8;
    localparam int G    = 4;
    localparam int N    = 3;
    localparam int W    = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          pll_locked = 1'b0;
    logic          soft_reset_req = 1'b0;
    logic [N-1:0]  rst_out;
    logic          all_released;
    logic [2:0]    seq_state;
    logic [W-1:0]  lock_loss_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC),
        .LOCK_STABLE_CYCLES(L),
        .STAGE_GAP_CYCLES  (G),
        .NUM_RESETS        (N),
        .LOSS_CNT_W        (W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .rst_out        (rst_out),
        .all_released   (all_released),
        .seq_state      (seq_state),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clock = ~clock;

    // Timeline model: rel_edge is the edge at which bit 0 is (or will be) released,
    // bit k drops at rel_edge + k*G; stab_edge is the edge a stable lock was first seen.
    int        edge_n    = 0;
    int        rel_edge  = -1;
    int        stab_edge = -1;
    int        m_loss    = 0;
    logic [SYNC-1:0] m_sync = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rel_edge  <= -1;
            stab_edge <= -1;
            m_loss    <= 0;
            m_sync    <= '0;
        end else begin
            automatic int  n  = edge_n + 1;
            automatic bit  ls = m_sync[SYNC-1];
            if (rel_edge >= 0) begin
                if (!ls) begin
                    m_loss    <= (m_loss == (1 << W) - 1) ? m_loss : m_loss + 1;
                    rel_edge  <= -1;
                    stab_edge <= -1;
                end else if (edge_n >= rel_edge + (N - 1) * G && soft_reset_req) begin
                    rel_edge <= n + G;
                end
            end else if (stab_edge >= 0) begin
                if (!ls) begin
                    stab_edge <= -1;
                end else if (n == stab_edge + L) begin
                    rel_edge  <= n;
                    stab_edge <= -1;
                end
            end else if (ls) begin
                stab_edge <= n;
            end
            m_sync <= {m_sync[SYNC-2:0], pll_locked};
        end
    end

    always @(posedge clock) edge_n <= edge_n + 1;

    logic [N-1:0] exp_rst;
    logic         exp_all;
    logic [2:0]   exp_state;

    always @* begin
        for (int k = 0; k < N; k++) begin
            exp_rst[k] = !(rel_edge >= 0 && edge_n >= rel_edge + k * G);
        end
        exp_all = (rel_edge >= 0) && (edge_n >= rel_edge + (N - 1) * G);
        if (rel_edge >= 0) begin
            if (edge_n < rel_edge)                 exp_state = 3'd4;
            else if (edge_n >= rel_edge + (N - 1) * G) exp_state = 3'd3;
            else                                   exp_state = 3'd2;
        end else if (stab_edge >= 0) begin
            exp_state = 3'd1;
        end else begin
            exp_state = 3'd0;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            checks++;
            if (rst_out !== exp_rst || all_released !== exp_all ||
                seq_state !== exp_state || lock_loss_count !== W'(m_loss)) begin
                errors++;
                $display("FAIL model t=%0t: got rst=%b all=%b st=%0d cnt=%0d expected rst=%b all=%b st=%0d cnt=%0d",
                         $time, rst_out, all_released, seq_state, lock_loss_count,
                         exp_rst, exp_all, exp_state, m_loss);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic lock_to_run();
        pll_locked = 1'b1;
        tick(1 + 18);
    endtask

    int exp_loss[4] = '{1, 2, 3, 3};

    initial begin
        #1 reset_n = 1'b0;
        cmp_en = 1'b1;
        tick(3);
        reset_n = 1'b1;

        tick(20);
        chk("powerup_rst", 32'(rst_out), 32'd7);
        chk("powerup_all", 32'(all_released), 32'd0);
        chk("powerup_state", 32'(seq_state), 32'd0);

        // Lock acquisition: first capture at edge E = next edge.
        pll_locked = 1'b1;
        tick(1);
        tick(9);
        chk("acq_e9_rst", 32'(rst_out), 32'd7);
        tick(1);
        chk("acq_e10_rst", 32'(rst_out), 32'd6);
        tick(3);
        chk("acq_e13_rst", 32'(rst_out), 32'd6);
        tick(1);
        chk("acq_e14_rst", 32'(rst_out), 32'd4);
        tick(4);
        chk("acq_e18_rst", 32'(rst_out), 32'd0);
        chk("acq_e18_all", 32'(all_released), 32'd1);
        chk("acq_loss", 32'(lock_loss_count), 32'd0);

        // Soft reset from RUN.
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        chk("soft_entry_rst", 32'(rst_out), 32'd7);
        chk("soft_entry_state", 32'(seq_state), 32'd4);
        tick(3);
        chk("soft_hold_rst", 32'(rst_out), 32'd7);
        tick(1);
        chk("soft_b0_rst", 32'(rst_out), 32'd6);
        tick(4);
        chk("soft_b1_rst", 32'(rst_out), 32'd4);
        tick(4);
        chk("soft_b2_rst", 32'(rst_out), 32'd0);
        chk("soft_loss", 32'(lock_loss_count), 32'd0);

        // Soft request on the same cycle locked_s falls.
        pll_locked = 1'b0;
        tick(2);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        chk("simul_state", 32'(seq_state), 32'd0);
        chk("simul_loss", 32'(lock_loss_count), 32'd1);

        // Soft request during STABILIZE is ignored.
        pll_locked = 1'b1;
        tick(4);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        tick(14);
        chk("stab_soft_state", 32'(seq_state), 32'd3);

        // Lock drop during SOFT_HOLD.
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        pll_locked = 1'b0;
        tick(3);
        chk("hold_drop_state", 32'(seq_state), 32'd0);
        chk("hold_drop_loss", 32'(lock_loss_count), 32'd2);

        // Lock drop during RELEASE.
        pll_locked = 1'b1;
        tick(1 + 11);
        pll_locked = 1'b0;
        tick(3);
        chk("rel_drop_rst", 32'(rst_out), 32'd7);
        chk("rel_drop_loss", 32'(lock_loss_count), 32'd3);

        // Async reset mid-RELEASE.
        pll_locked = 1'b1;
        tick(1 + 12);
        chk("pre_arst_rst", 32'(rst_out), 32'd6);
        reset_n = 1'b0;
        #1;
        chk("arst_rst", 32'(rst_out), 32'd7);
        chk("arst_loss", 32'(lock_loss_count), 32'd0);
        chk("arst_state", 32'(seq_state), 32'd0);
        pll_locked = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(3);

        // Lock glitch: high 5 cycles, low 1, high again.
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        tick(9);
        chk("glitch_e9_rst", 32'(rst_out), 32'd7);
        chk("glitch_loss", 32'(lock_loss_count), 32'd0);
        tick(1);
        chk("glitch_e10_rst", 32'(rst_out), 32'd6);
        tick(8);

        // Repeated lock loss in RUN, counter saturates.
        for (int i = 0; i < 4; i++) begin
            pll_locked = 1'b0;
            tick(2);
            chk("loss_pre_rst", 32'(rst_out), 32'd0);
            tick(1);
            chk("loss_rst", 32'(rst_out), 32'd7);
            chk("loss_cnt", 32'(lock_loss_count), 32'(exp_loss[i]));
            lock_to_run();
            chk("loss_relock_state", 32'(seq_state), 32'd3);
        end

        // Randomized phase, checked against the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 59) == 0) pll_locked = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) pll_locked = 1'b1;
            end
            soft_reset_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                tick(1);
                reset_n = 1'b1;
            end else begin
                tick(1);
            end
        end
        soft_reset_req = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
